// File: rtl/dynamic_capture_pkg.sv
// Shared definitions for the dynamic_capture slice.
// Contents:
//   - DIGIT_W: width of one BCD digit.
//   - Slot codes for the active-low anode select lines.
//   - Capture FSM state type.
//   - Helper that tells whether a nibble is a decimal digit.
package dynamic_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] SLOT1   = 2'b01;
  localparam logic [1:0] SLOT2   = 2'b10;
  localparam logic [1:0] BLANK   = 2'b11;
  localparam logic [1:0] ILLEGAL = 2'b00;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no slot committed
    HALF = 2'd1,  // exactly one slot committed
    LOCK = 2'd2   // both slots committed
  } state_e;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_digit(input logic [DIGIT_W-1:0] value);
    return (value <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/dynamic_capture_if.sv
// Bundle of the scanned-display sample inputs and the captured results.
// Signals:
//   an    - scanned anode select, active-low (01 slot 1, 10 slot 2, 11 blank)
//   bcd   - digit value presented with an
//   out1  - committed slot-1 digit
//   out2  - committed slot-2 digit
//   valid - both slots committed and no timeout since
//   upd   - one-cycle pulse when out1 or out2 is written
//   err   - sticky illegal-sample flag
// Modports: master drives the samples, slave (the capture block) drives results.
interface dynamic_capture_if;
  import dynamic_pkg::*;

  logic [1:0]         an;
  logic [DIGIT_W-1:0] bcd;
  logic [DIGIT_W-1:0] out1;
  logic [DIGIT_W-1:0] out2;
  logic               valid;
  logic               upd;
  logic               err;

  modport master (
    output an, bcd,
    input  out1, out2, valid, upd, err
  );

  modport slave (
    input  an, bcd,
    output out1, out2, valid, upd, err
  );

endinterface

// File: rtl/dynamic_capture_digit_filter.sv
// Per-slot debounce filter: tracks a candidate digit and how many consecutive
// legal samples matched it, and commits the candidate once it has been seen
// CONFIRM times in a row (unless it is already the committed value).
// Ports:
//   clk_e     - clock, rising edge
//   rst       - asynchronous active-low reset
//   sample    - a legal sample for this slot is present this cycle
//   digit     - the sample's digit value
//   clear     - drop the committed flag and match count (timeout)
//   value     - committed digit (registered)
//   upd       - one-cycle pulse when value was written (registered)
//   committed - slot currently holds a committed value (registered)
//   commit    - this edge commits a value (combinational, for the FSM)
module digit_filter
  import dynamic_pkg::*;
#(
  parameter int CONFIRM = 2
) (
  input  logic               clk_e,
  input  logic               rst,
  input  logic               sample,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear,
  output logic [DIGIT_W-1:0] value,
  output logic               upd,
  output logic               committed,
  output logic               commit
);

  localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);

  logic [DIGIT_W-1:0] cand_r;
  logic [3:0]         cnt_r;
  logic [DIGIT_W-1:0] value_r;
  logic               upd_r;
  logic               committed_r;

  logic [DIGIT_W-1:0] cand_next_s;
  logic [3:0]         cnt_next_s;
  logic               commit_s;

  // Next candidate/count and the commit decision for this edge.
  always_comb begin
    cand_next_s = cand_r;
    cnt_next_s  = cnt_r;
    commit_s    = 1'b0;
    if (sample) begin
      if (digit == cand_r) begin
        cnt_next_s = (cnt_r >= CONFIRM_C) ? CONFIRM_C : (cnt_r + 4'd1);
      end else begin
        cand_next_s = digit;
        cnt_next_s  = 4'd1;
      end
      // A saturated count on the value already shown must not re-commit.
      commit_s = (cnt_next_s == CONFIRM_C) &&
                 (!committed_r || (cand_next_s != value_r));
    end else if (clear) begin
      cnt_next_s = 4'd0;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Candidate, count, committed value and update pulse registers.
  always_ff @(posedge clk_e or negedge rst) begin
    if (!rst) begin
      cand_r      <= 4'd0;
      cnt_r       <= 4'd0;
      value_r     <= 4'd0;
      upd_r       <= 1'b0;
      committed_r <= 1'b0;
    end else begin
      cand_r <= cand_next_s;
      cnt_r  <= cnt_next_s;
      upd_r  <= commit_s;
      if (commit_s) begin
        value_r     <= cand_next_s;
        committed_r <= 1'b1;
      end else if (clear) begin
        committed_r <= 1'b0;
      end else begin
        committed_r <= committed_r;
      end
    end
  end

  assign value     = value_r;
  assign upd       = upd_r;
  assign committed = committed_r;
  assign commit    = commit_s;

endmodule

// File: rtl/dynamic_capture.sv
// Captures the two digits of a multiplexed (scanned) two-digit display.
// Samples are registered once, filtered per slot, and a small FSM reports
// when both digits are stable. A run of TIMEOUT cycles without a legal
// sample drops the lock but keeps the last displayed digits.
// Ports:
//   clk_e - sole clock, rising edge
//   rst   - asynchronous active-low reset
//   bus   - slave side of dynamic_capture_if (an/bcd in; out1/out2/valid/upd/err out)
module dynamic_capture
  import dynamic_pkg::*;
#(
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_e,
  input  logic              rst,
  dynamic_capture_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]         an_r;
  logic [DIGIT_W-1:0] bcd_r;
  logic [7:0]         tcnt_r;
  state_e             state_r;
  logic               valid_r;
  logic               err_r;

  state_e             state_next_s;
  logic               slot1_s;
  logic               slot2_s;
  logic               legal_s;
  logic               illegal_s;
  logic               timeout_s;

  logic [DIGIT_W-1:0] value1_s;
  logic [DIGIT_W-1:0] value2_s;
  logic               upd1_s;
  logic               upd2_s;
  logic               committed1_s;
  logic               committed2_s;
  logic               commit1_s;
  logic               commit2_s;

  // Input stage: every decision below uses these registered copies.
  always_ff @(posedge clk_e or negedge rst) begin
    if (!rst) begin
      an_r  <= BLANK;
      bcd_r <= 4'd0;
    end else begin
      an_r  <= bus.an;
      bcd_r <= bus.bcd;
    end
  end

  assign slot1_s   = (an_r == SLOT1) && is_digit(bcd_r);
  assign slot2_s   = (an_r == SLOT2) && is_digit(bcd_r);
  assign legal_s   = slot1_s || slot2_s;
  assign illegal_s = (an_r == ILLEGAL) ||
                     (((an_r == SLOT1) || (an_r == SLOT2)) && !is_digit(bcd_r));
  // Fires on the edge where the idle count reaches TIMEOUT and stays asserted
  // while it is saturated; a legal sample always wins.
  assign timeout_s = !legal_s && (tcnt_r >= (TIMEOUT_C - 8'd1));

  digit_filter #(.CONFIRM(CONFIRM)) u_slot1 (
    .clk_e     (clk_e),
    .rst       (rst),
    .sample    (slot1_s),
    .digit     (bcd_r),
    .clear     (timeout_s),
    .value     (value1_s),
    .upd       (upd1_s),
    .committed (committed1_s),
    .commit    (commit1_s)
  );

  digit_filter #(.CONFIRM(CONFIRM)) u_slot2 (
    .clk_e     (clk_e),
    .rst       (rst),
    .sample    (slot2_s),
    .digit     (bcd_r),
    .clear     (timeout_s),
    .value     (value2_s),
    .upd       (upd2_s),
    .committed (committed2_s),
    .commit    (commit2_s)
  );

  // Capture FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (timeout_s) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (commit1_s || commit2_s) begin
            state_next_s = HALF;
          end else begin
            state_next_s = IDLE;
          end
        end
        HALF: begin
          // Only a first commit of the still-empty slot completes the lock.
          if ((commit1_s && !committed1_s) || (commit2_s && !committed2_s)) begin
            state_next_s = LOCK;
          end else begin
            state_next_s = HALF;
          end
        end
        LOCK: begin
          state_next_s = LOCK;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM state, valid flag, sticky error flag and idle-cycle counter.
  always_ff @(posedge clk_e or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      tcnt_r  <= 8'd0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == LOCK);
      err_r   <= err_r || illegal_s;
      if (legal_s) begin
        tcnt_r <= 8'd0;
      end else if (tcnt_r < TIMEOUT_C) begin
        tcnt_r <= tcnt_r + 8'd1;
      end else begin
        tcnt_r <= tcnt_r;
      end
    end
  end

  assign bus.out1  = value1_s;
  assign bus.out2  = value2_s;
  assign bus.upd   = upd1_s || upd2_s;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;

endmodule
